// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pci_pkg
// Purpose  : Shared types and constants for the simplified PCI target.
// Revision : 1.0 - initial release
// ============================================================================
package pci_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OTHER  = 3'd1,
        W_DATA = 3'd2,
        R_TURN = 3'd3,
        R_DATA = 3'd4,
        FINISH = 3'd5
    } pci_state_e;

    localparam int CMD_WRITE     = 3;
    localparam int CMD_COUNT_MSB = 2;
    localparam int CMD_COUNT_LSB = 0;

    localparam logic ASSERTED = 1'b0;
    localparam logic RELEASED = 1'b1;

    typedef struct packed {
        logic       write;
        logic [2:0] count;
    } cmd_t;

    // A zero count field encodes the longest burst of eight phases.
    function automatic logic [3:0] burst_limit(input logic [2:0] count);
        return (count == 3'd0) ? 4'd8 : {1'b0, count};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_if.sv
`default_nettype none
// ============================================================================
// Module   : pci_target_if
// Purpose  : Shared PCI bus nets with per-agent drivers resolved in one place.
// Revision : 1.0 - initial release
// ============================================================================
interface pci_target_if;

    wire  [31:0] AD;
    logic [3:0]  CBE;
    logic        iframe;
    logic        iready;
    wire         tready;
    wire         devsel;

    logic [31:0] ini_ad;
    logic        ini_ad_oe;

    logic [31:0] tgt_ad;
    logic        tgt_ad_oe;
    logic        tgt_ctl_oe;
    logic        tgt_tready;
    logic        tgt_devsel;

    // Each agent only drives while its enable is set; otherwise the net floats.
    assign AD     = ini_ad_oe  ? ini_ad     : {32{1'bz}};
    assign AD     = tgt_ad_oe  ? tgt_ad     : {32{1'bz}};
    assign tready = tgt_ctl_oe ? tgt_tready : 1'bz;
    assign devsel = tgt_ctl_oe ? tgt_devsel : 1'bz;

    modport master (
        output CBE, iframe, iready, ini_ad, ini_ad_oe,
        input  AD, tready, devsel
    );

    modport slave (
        input  AD, CBE, iframe, iready,
        output tgt_ad, tgt_ad_oe, tgt_ctl_oe, tgt_tready, tgt_devsel
    );

endinterface
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// ============================================================================
// Module   : pci_target_mem
// Purpose  : Byte-enabled word store with a bus read port and a debug port.
// Revision : 1.0 - initial release
// ============================================================================
module pci_target_mem #(
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [31:0]   i_wdata,
    input  wire logic [3:0]    i_wbe,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [31:0]   o_rdata,
    input  wire logic [3:0]    i_dbg_addr,
    output logic      [31:0]   o_dbg_data
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Indices past the last word read as zero instead of aliasing.
    assign o_rdata    = (int'(i_raddr)    < DEPTH) ? r_mem[i_raddr]    : '0;
    assign o_dbg_data = (int'(i_dbg_addr) < DEPTH) ? r_mem[i_dbg_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/pci_target.sv
`default_nettype none
// ============================================================================
// Module   : pci_target
// Purpose  : PCI responder claiming DEV_ADDR and serving bursts to local memory.
// Revision : 1.0 - initial release
// ============================================================================
module pci_target
    import pci_pkg::*;
#(
    parameter logic [31:0] DEV_ADDR = 32'h0000_0010,
    parameter int          DEPTH    = 10
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pci_target_if.slave      bus,
    output logic             busy,
    output logic             overrun,
    input  wire logic [3:0]  dbg_addr,
    output logic      [31:0] dbg_data
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST_PTR = AW'(DEPTH - 1);

    pci_state_e    r_state;
    pci_state_e    w_state_nxt;
    logic          r_iframe_q;
    logic [3:0]    r_limit;
    logic [AW-1:0] r_ptr;
    logic [3:0]    r_count;
    logic [31:0]   r_ad;
    logic          r_overrun;

    cmd_t          w_cmd;
    logic          w_addr_phase;
    logic          w_claim;
    logic          w_phase_done;
    logic          w_burst_end;
    logic          w_overrun;
    logic [AW-1:0] w_ptr_inc;
    logic [3:0]    w_count_inc;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_rdata;
    logic          w_ctl_oe;
    logic          w_tready;
    logic          w_devsel;
    logic          w_ad_oe;

    assign w_cmd        = cmd_t'(bus.CBE);
    assign w_addr_phase = (bus.iframe == ASSERTED) && (r_iframe_q == RELEASED);
    assign w_claim      = w_addr_phase && (bus.AD == DEV_ADDR);

    // A phase completes only when both sides are ready; tready is our own drive.
    assign w_phase_done = w_ctl_oe && (w_tready == ASSERTED) && (bus.iready == ASSERTED);
    assign w_burst_end  = w_phase_done && (bus.iframe == RELEASED);
    assign w_count_inc  = r_count + 4'd1;
    assign w_overrun    = w_phase_done && (bus.iframe == ASSERTED) && (w_count_inc == r_limit);
    assign w_ptr_inc    = (r_ptr == C_LAST_PTR) ? '0 : r_ptr + AW'(1);

    // During R_DATA the word for the following phase is fetched ahead.
    assign w_raddr = (r_state == R_DATA) ? w_ptr_inc : r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_addr_phase) begin
                    if (!w_claim) begin
                        w_state_nxt = OTHER;
                    end else if (w_cmd.write) begin
                        w_state_nxt = W_DATA;
                    end else begin
                        w_state_nxt = R_TURN;
                    end
                end
            end
            OTHER: begin
                if ((bus.iframe == RELEASED) && (bus.iready == RELEASED)) begin
                    w_state_nxt = IDLE;
                end
            end
            W_DATA, R_DATA: begin
                if (w_burst_end || w_overrun) begin
                    w_state_nxt = FINISH;
                end
            end
            R_TURN:  w_state_nxt = R_DATA;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ctl_oe = 1'b0;
        w_tready = RELEASED;
        w_devsel = RELEASED;
        w_ad_oe  = 1'b0;
        busy     = 1'b1;
        unique case (r_state)
            IDLE:  busy = 1'b0;
            OTHER: busy = 1'b1;
            W_DATA: begin
                w_ctl_oe = 1'b1;
                w_tready = ASSERTED;
                w_devsel = ASSERTED;
            end
            R_TURN: begin
                w_ctl_oe = 1'b1;
                w_devsel = ASSERTED;
            end
            R_DATA: begin
                w_ctl_oe = 1'b1;
                w_tready = ASSERTED;
                w_devsel = ASSERTED;
                w_ad_oe  = 1'b1;
            end
            FINISH:  w_ctl_oe = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iframe_q <= RELEASED;
            r_limit    <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_ad       <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_iframe_q <= bus.iframe;
            r_overrun  <= w_overrun;
            if ((r_state == IDLE) && w_claim) begin
                r_limit <= burst_limit(w_cmd.count);
                r_ptr   <= '0;
                r_count <= '0;
            end
            if (w_phase_done) begin
                r_ptr   <= w_ptr_inc;
                r_count <= w_count_inc;
            end
            if ((r_state == R_TURN) || ((r_state == R_DATA) && w_phase_done)) begin
                r_ad <= w_rdata;
            end
        end
    end

    pci_target_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk        (clk),
        .rst        (reset),
        .i_we       (w_phase_done && (r_state == W_DATA)),
        .i_waddr    (r_ptr),
        .i_wdata    (bus.AD),
        .i_wbe      (bus.CBE),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    assign bus.tgt_ad     = r_ad;
    assign bus.tgt_ad_oe  = w_ad_oe;
    assign bus.tgt_ctl_oe = w_ctl_oe;
    assign bus.tgt_tready = w_tready;
    assign bus.tgt_devsel = w_devsel;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pci_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_pci_target
// Purpose  : Directed scoreboard bench for pci_target bursts, misses and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pci_target;
    import pci_pkg::*;

    localparam logic [31:0] DEV   = 32'h0000_0010;
    localparam int          DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        overrun;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    pci_target_if bus();

    pci_target #(.DEV_ADDR(DEV), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .overrun  (overrun),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ovr_pulses = 0;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] rd_q [$];
    logic [31:0] wdat [12];
    logic [3:0]  wbe  [12];

    always @(negedge clk) if (overrun === 1'b1) ovr_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.iframe    = RELEASED;
        bus.iready    = RELEASED;
        bus.ini_ad_oe = 1'b0;
        bus.ini_ad    = '0;
        bus.CBE       = '0;
    endtask

    task automatic check_mem(input int i);
        dbg_addr = i[3:0];
        #1;
        check($sformatf("mem%0d", i), dbg_data, exp_mem[i]);
    endtask

    // Offers n data phases; the model applies only phases the target accepts.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] cmd,
                               input int n, input bit last_high);
        int limit;
        int ptr;
        bit claimed;
        limit   = (cmd[2:0] == 3'd0) ? 8 : int'(cmd[2:0]);
        claimed = (addr == DEV);
        ptr     = 0;
        bus.iframe    = ASSERTED;
        bus.iready    = RELEASED;
        bus.ini_ad    = addr;
        bus.ini_ad_oe = 1'b1;
        bus.CBE       = cmd;
        tick();
        check("w_busy", 32'(busy), 32'd1);
        if (claimed) begin
            check("w_devsel", 32'(bus.devsel), 32'(ASSERTED));
            check("w_tready", 32'(bus.tready), 32'(ASSERTED));
        end else begin
            check("miss_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd0);
        end
        for (int k = 0; k < n; k++) begin
            if (claimed && k == limit) begin
                check("ovr_pulse", 32'(overrun), 32'd1);
                check("ovr_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd1);
                check("ovr_tready", 32'(bus.tready), 32'(RELEASED));
            end
            bus.ini_ad = wdat[k];
            bus.CBE    = wbe[k];
            bus.iready = ASSERTED;
            bus.iframe = (last_high && k == n - 1) ? RELEASED : ASSERTED;
            if (claimed && k < limit) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbe[k][b]) exp_mem[ptr][8*b +: 8] = wdat[k][8*b +: 8];
                end
                ptr = (ptr == DEPTH - 1) ? 0 : ptr + 1;
            end
            tick();
        end
    endtask

    // Read from word 0 with one initiator wait state before the first phase.
    task automatic read_burst(input logic [3:0] cmd, input int n, input int abort_after);
        bus.iframe    = ASSERTED;
        bus.iready    = RELEASED;
        bus.ini_ad    = DEV;
        bus.ini_ad_oe = 1'b1;
        bus.CBE       = cmd;
        for (int k = 0; k < n; k++) rd_q.push_back(exp_mem[k]);
        tick();
        check("turn_ad_oe", 32'(bus.tgt_ad_oe), 32'd0);
        check("turn_devsel", 32'(bus.devsel), 32'(ASSERTED));
        check("turn_tready", 32'(bus.tready), 32'(RELEASED));
        bus.ini_ad_oe = 1'b0;
        bus.CBE       = 4'hF;
        tick();
        check("rd_first", bus.AD, rd_q[0]);
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == abort_after) begin
                reset = 1'b1;
                bus_idle();
                rd_q.delete();
                tick();
                reset = 1'b0;
                break;
            end
            check("rd_tready", 32'(bus.tready), 32'(ASSERTED));
            check("rd_data", bus.AD, rd_q.pop_front());
            bus.iready = ASSERTED;
            bus.iframe = (k == n - 1) ? RELEASED : ASSERTED;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ovr_before;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        reset    = 1'b1;
        dbg_addr = '0;
        bus_idle();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd0);
        check("rst_ad_oe", 32'(bus.tgt_ad_oe), 32'd0);
        check_mem(0);
        reset = 1'b0;
        tick();

        // Three-word write ending with iframe high on the last phase.
        wdat[0] = 32'h0000_00A1; wdat[1] = 32'h0000_00B2; wdat[2] = 32'h0000_00C3;
        wbe[0]  = 4'hF; wbe[1] = 4'hF; wbe[2] = 4'hF;
        write_burst(DEV, 4'b1011, 3, 1'b1);
        bus_idle();
        check("fin_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd1);
        check("fin_tready", 32'(bus.tready), 32'(RELEASED));
        check("fin_devsel", 32'(bus.devsel), 32'(RELEASED));
        tick();
        check("rel_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) check_mem(i);
        dbg_addr = 4'd12;
        #1;
        check("dbg_oob", dbg_data, 32'd0);

        // Two-word read with a wait state; expectations come from the model.
        read_burst(4'b0010, 2, -1);
        bus_idle();
        check("rd_fin_ad_oe", 32'(bus.tgt_ad_oe), 32'd0);
        check("rd_fin_tready", 32'(bus.tready), 32'(RELEASED));
        tick();
        check("rd_rel_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd0);

        // Partial write: only the enabled bytes change.
        wdat[0] = 32'h1234_5678; wbe[0] = 4'hF;
        write_burst(DEV, 4'b1001, 1, 1'b1);
        bus_idle();
        tick();
        wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'b0101;
        write_burst(DEV, 4'b1001, 1, 1'b1);
        bus_idle();
        tick();
        check_mem(0);
        check("partial_const", exp_mem[0], 32'h12FF_56FF);

        // Miss: target stays off the bus until iframe and iready both release.
        wdat[0] = 32'hDEAD_0000; wdat[1] = 32'hDEAD_0001;
        wbe[0]  = 4'hF; wbe[1] = 4'hF;
        write_burst(32'h0000_0020, 4'b1010, 2, 1'b0);
        bus.iframe    = RELEASED;
        bus.ini_ad_oe = 1'b0;
        tick();
        check("miss_busy_hold", 32'(busy), 32'd1);
        check("miss_ctl_hold", 32'(bus.tgt_ctl_oe), 32'd0);
        bus_idle();
        tick();
        check("miss_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) check_mem(i);

        // Overrun: count field 0 allows eight phases, twelve are offered.
        ovr_before = ovr_pulses;
        for (int k = 0; k < 12; k++) begin
            wdat[k] = 32'h0000_0100 + 32'(k);
            wbe[k]  = 4'hF;
        end
        write_burst(DEV, 4'b1000, 12, 1'b0);
        bus_idle();
        tick();
        tick();
        #1;
        check("ovr_count", 32'(ovr_pulses - ovr_before), 32'd1);
        check("ovr_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) check_mem(i);

        // Reset after the second read phase of a four-word read.
        read_burst(4'b0100, 4, 2);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        check("mrst_ctl_oe", 32'(bus.tgt_ctl_oe), 32'd0);
        check("mrst_ad_oe", 32'(bus.tgt_ad_oe), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) check_mem(i);
        tick();

        // An address phase landing in the FINISH cycle is not claimed.
        wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
        write_burst(DEV, 4'b1001, 1, 1'b1);
        bus.iframe    = ASSERTED;
        bus.iready    = RELEASED;
        bus.ini_ad    = DEV;
        bus.ini_ad_oe = 1'b1;
        bus.CBE       = 4'b1001;
        tick();
        check("b2b_ctl_oe0", 32'(bus.tgt_ctl_oe), 32'd0);
        bus.ini_ad = 32'h5555_5555;
        bus.CBE    = 4'hF;
        bus.iready = ASSERTED;
        bus.iframe = RELEASED;
        tick();
        check("b2b_ctl_oe1", 32'(bus.tgt_ctl_oe), 32'd0);
        bus_idle();
        tick();
        check_mem(0);
        check_mem(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
